// File: rtl/riscv_mtimer_pkg.sv
// Shared machine-timer definitions: register offsets, dmem_op encodings, byte-lane helpers.
// Latency: none (pure definitions). Backpressure: not applicable.
package riscv_mtimer_pkg;

    localparam logic [1:0] MTIME_LO    = 2'd0;
    localparam logic [1:0] MTIME_HI    = 2'd1;
    localparam logic [1:0] MTIMECMP_LO = 2'd2;
    localparam logic [1:0] MTIMECMP_HI = 2'd3;

    // dmem_op[1:0] sizes; 2'd1 also decodes as a byte access.
    localparam logic [1:0] OP_BYTE  = 2'd0;
    localparam logic [1:0] OP_HALF  = 2'd2;
    localparam logic [1:0] OP_WORD  = 2'd3;
    localparam int         OP_STORE = 2;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
        case (size)
            OP_HALF: return a[1] ? 4'b1100 : 4'b0011;
            OP_WORD: return 4'b1111;
            default: return 4'b0001 << a;
        endcase
    endfunction

    // Byte offset of the access after masking addr[1:0] to the access alignment.
    function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] a);
        case (size)
            OP_HALF: return {a[1], 1'b0};
            OP_WORD: return 2'd0;
            default: return a;
        endcase
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        case (size)
            OP_HALF: return 32'h0000_ffff;
            OP_WORD: return 32'hffff_ffff;
            default: return 32'h0000_00ff;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] mask);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/riscv_mtimer_prescaler.sv
// mtime tick divider: one tick every PRESCALE enabled cycles, combinational tick output.
// Latency: tick is combinational from count_en. Backpressure: none; count_en low freezes the count.
module riscv_mtimer_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    output logic tick
);
    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] pcount;

    assign tick = count_en & (pcount == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pcount <= '0;
        end else if (tick) begin
            pcount <= '0;
        end else if (count_en) begin
            pcount <= pcount + 16'd1;
        end
    end

endmodule

// File: rtl/riscv_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp) on the data bus; loads return 1 cycle later, stores take 1 cycle.
// Backpressure: none, a request every cycle is accepted. MTIMER_SNAPSHOT_EN adds a tear-free hi snapshot.
module riscv_mtimer
    import riscv_mtimer_pkg::*;
#(
    parameter logic [31:0] BASE     = 32'h0000c000,
    parameter int          PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [2:0]  dmem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        count_en,
    output logic        timer_irq
);
    logic [63:0] mtime, mtimecmp, mtime_nxt, mtimecmp_nxt;
    logic        tick, store, load;
    logic [1:0]  reg_idx, off;
    logic [3:0]  mask;
    logic [31:0] wsh, rword, hi_rd;

    assign sel     = valid & (addr[31:4] == BASE[31:4]);
    assign store   = sel & dmem_op[OP_STORE];
    assign load    = sel & ~dmem_op[OP_STORE];
    assign reg_idx = addr[3:2];
    assign off     = lane_off(dmem_op[1:0], addr[1:0]);
    assign mask    = lane_mask(dmem_op[1:0], addr[1:0]);
    assign wsh     = wdata << {off, 3'b000};

    riscv_mtimer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .count_en (count_en),
        .tick     (tick)
    );

    // A store to either mtime half swallows a coincident tick entirely, so no carry leaks across halves.
    always_comb begin
        mtime_nxt    = mtime;
        mtimecmp_nxt = mtimecmp;
        if (store && reg_idx == MTIME_LO) begin
            mtime_nxt[31:0] = lane_merge(mtime[31:0], wsh, mask);
        end else if (store && reg_idx == MTIME_HI) begin
            mtime_nxt[63:32] = lane_merge(mtime[63:32], wsh, mask);
        end else if (tick) begin
            mtime_nxt = mtime + 64'd1;
        end
        if (store && reg_idx == MTIMECMP_LO) begin
            mtimecmp_nxt[31:0] = lane_merge(mtimecmp[31:0], wsh, mask);
        end
        if (store && reg_idx == MTIMECMP_HI) begin
            mtimecmp_nxt[63:32] = lane_merge(mtimecmp[63:32], wsh, mask);
        end
    end

`ifdef MTIMER_SNAPSHOT_EN
    logic [31:0] snap;

    always_ff @(posedge clk) begin
        if (rst) begin
            snap <= '0;
        end else if (load && reg_idx == MTIME_LO) begin
            snap <= mtime[63:32];
        end
    end

    assign hi_rd = snap;
`else
    assign hi_rd = mtime[63:32];
`endif

    always_comb begin
        case (reg_idx)
            MTIME_LO:    rword = mtime[31:0];
            MTIME_HI:    rword = hi_rd;
            MTIMECMP_LO: rword = mtimecmp[31:0];
            default:     rword = mtimecmp[63:32];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            rdata     <= '0;
            rvalid    <= 1'b0;
            timer_irq <= 1'b0;
        end else begin
            mtime     <= mtime_nxt;
            mtimecmp  <= mtimecmp_nxt;
            timer_irq <= (mtime >= mtimecmp);
            rvalid    <= load;
            if (load) begin
                rdata <= (rword >> {off, 3'b000}) & size_mask(dmem_op[1:0]);
            end
        end
    end

endmodule

// File: tb/tb_riscv_mtimer.sv
// Directed self-checking bench for riscv_mtimer: PRESCALE=1 instance plus a PRESCALE=4 instance.
module tb_riscv_mtimer;
    localparam logic [31:0] BASE = 32'h0000c000;
    localparam logic [2:0]  LW = 3'b011, LH = 3'b010, LB = 3'b000, SW = 3'b111, SB = 3'b100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0, count_en = 1'b0;
    logic [2:0]  dmem_op = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic        sel, rvalid, timer_irq;
    logic [31:0] rdata;

    logic        valid4 = 1'b0, count_en4 = 1'b0;
    logic [2:0]  dmem_op4 = '0;
    logic [31:0] addr4 = '0, wdata4 = '0;
    logic        sel4, rvalid4, timer_irq4;
    logic [31:0] rdata4;

    int total = 0;
    int bad   = 0;

    riscv_mtimer #(.BASE(BASE), .PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .valid(valid), .dmem_op(dmem_op), .addr(addr), .wdata(wdata),
        .sel(sel), .rdata(rdata), .rvalid(rvalid), .count_en(count_en), .timer_irq(timer_irq)
    );

    riscv_mtimer #(.BASE(BASE), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .valid(valid4), .dmem_op(dmem_op4), .addr(addr4), .wdata(wdata4),
        .sel(sel4), .rdata(rdata4), .rvalid(rvalid4), .count_en(count_en4), .timer_irq(timer_irq4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic acc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        valid = 1'b1; dmem_op = op; addr = a; wdata = d;
        step(1);
        valid = 1'b0;
    endtask

    task automatic acc4(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        valid4 = 1'b1; dmem_op4 = op; addr4 = a; wdata4 = d;
        step(1);
        valid4 = 1'b0;
    endtask

    initial begin
        step(3);
        check("rst_rdata", rdata, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_irq", timer_irq, 0);

        rst = 1'b0; count_en = 1'b1;
        step(10);
        acc(LW, BASE, 0);
        check("count10_rdata", rdata, 10);
        check("count10_rvalid", rvalid, 1);
        check("count10_irq", timer_irq, 0);

        count_en = 1'b0;
        acc(SW, BASE + 0, 0);
        check("rvalid_drop", rvalid, 0);
        acc(SW, BASE + 4, 0);
        acc(SW, BASE + 8, 5);
        acc(SW, BASE + 12, 0);
        count_en = 1'b1;
        step(5);
        check("irq_at5_low", timer_irq, 0);
        step(1);
        check("irq_rise", timer_irq, 1);
        acc(SW, BASE + 8, 100);
        check("irq_hold", timer_irq, 1);
        step(1);
        check("irq_fall", timer_irq, 0);

        count_en = 1'b0;
        acc(SW, BASE + 0, 32'hffff_ffff);
        acc(SW, BASE + 4, 0);
        count_en = 1'b1;
        step(1);
        count_en = 1'b0;
        acc(LW, BASE + 0, 0);
        check("carry_lo", rdata, 0);
        acc(LW, BASE + 4, 0);
        check("carry_hi", rdata, 1);

        acc(SB, BASE + 6, 32'h0000_00ab);
        acc(LW, BASE + 0, 0);
        check("sb_lo", rdata, 0);
        acc(LW, BASE + 4, 0);
        check("sb_hi", rdata, 32'h00ab_0001);
        acc(LB, BASE + 6, 0);
        check("lb_hi_lane2", rdata, 32'h0000_00ab);

        count_en = 1'b1;
        acc(SW, BASE + 0, 32'h1234_5678);
        count_en = 1'b0;
        acc(LW, BASE + 0, 0);
        check("store_beats_tick_lo", rdata, 32'h1234_5678);
        acc(LW, BASE + 4, 0);
        check("store_beats_tick_hi", rdata, 32'h00ab_0001);

        acc(SW, BASE + 8, 32'h1122_3344);
        acc(LH, BASE + 10, 0);
        check("lh_cmp_hi_half", rdata, 32'h0000_1122);
        acc(LB, BASE + 9, 0);
        check("lb_cmp_byte1", rdata, 32'h0000_0033);
        acc(LW, BASE + 12, 0);
        check("lw_cmp_hi", rdata, 0);

        valid = 1'b1; dmem_op = LW; addr = 32'h0000_d004;
        #1;
        check("sel_miss", sel, 0);
        addr = BASE + 4;
        #1;
        check("sel_hit", sel, 1);
        addr = 32'h0000_d004;
        step(1);
        valid = 1'b0;
        check("miss_no_rvalid", rvalid, 0);

        acc(SW, BASE + 0, 32'hffff_ffff);
        acc(SW, BASE + 4, 32'hffff_ffff);
        count_en = 1'b1;
        step(1);
        count_en = 1'b0;
        acc(LW, BASE + 0, 0);
        check("wrap_lo", rdata, 0);
        acc(LW, BASE + 4, 0);
        check("wrap_hi", rdata, 0);

`ifdef MTIMER_SNAPSHOT_EN
        acc(SW, BASE + 0, 32'hffff_ffff);
        acc(SW, BASE + 4, 1);
        acc(LW, BASE + 0, 0);
        check("snap_lo", rdata, 32'hffff_ffff);
        count_en = 1'b1;
        step(1);
        count_en = 1'b0;
        acc(LW, BASE + 4, 0);
        check("snap_hi", rdata, 1);
`endif

        count_en4 = 1'b1; step(2);
        count_en4 = 1'b0; step(1);
        count_en4 = 1'b1; step(1);
        count_en4 = 1'b0;
        acc4(LW, BASE + 0, 0);
        check("pre4_before", rdata4, 0);
        count_en4 = 1'b1; step(1);
        count_en4 = 1'b0;
        acc4(LW, BASE + 0, 0);
        check("pre4_after", rdata4, 1);
        check("pre4_rvalid", rvalid4, 1);
        check("pre4_irq", timer_irq4, 0);

        rst = 1'b1;
        acc(LW, BASE + 12, 0);
        check("rst_load_rvalid", rvalid, 0);
        check("rst_load_rdata", rdata, 0);
        rst = 1'b0;
        acc(LW, BASE + 12, 0);
        check("post_rst_cmp_hi", rdata, 32'hffff_ffff);
        acc(LW, BASE + 0, 0);
        check("post_rst_mtime_lo", rdata, 0);
        check("post_rst_irq", timer_irq, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
